// File: rtl/output_sram_req_arbiter_pkg.sv
// Shared types for the output feature SRAM write arbiter: bank request packet, SRAM write word, FSM states.
// Default geometry: 4 banks, 16-bit beats, 64 nodes, 4 beats per feature vector.
package output_sram_req_arbiter_pkg;
  localparam int NUM_VERTEX_UNIT = 4;
  localparam int FV_BANDWIDTH    = 16;
  localparam int FV_SIZE         = 64;
  localparam int MAX_NODE_ID     = 64;
  localparam int NODE_ID_W       = $clog2(MAX_NODE_ID);
  localparam int FV_BEATS        = FV_SIZE / FV_BANDWIDTH;
  localparam int OUT_ADDR_W      = NODE_ID_W + $clog2(FV_BEATS);

  typedef struct packed {
    logic                    req;
    logic                    grant_valid;
    logic                    sos;
    logic                    eos;
    logic [FV_BANDWIDTH-1:0] data;
    logic [NODE_ID_W-1:0]    node_id;
  } Bank_Req2Req_Output_SRAM;

  typedef struct packed {
    logic                    wen;
    logic [OUT_ADDR_W-1:0]   addr;
    logic [FV_BANDWIDTH-1:0] wdata;
  } Out_SRAM_Wr;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_STREAM
  } arb_state_e;
endpackage

// File: rtl/output_sram_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr, wrapping modulo N.
module output_sram_req_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] k;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = IDX_W'((int'(rr_ptr) + i) % N);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end
endmodule

// File: rtl/output_sram_req_arbiter.sv
// Round-robin arbiter streaming one bank's sos..eos feature vector into the output SRAM at {node_id, beat}.
// Grant registered one cycle after req; writes land one cycle after the accepted beat; one IDLE cycle between grants.
module output_sram_req_arbiter
  import output_sram_req_arbiter_pkg::*;
#(
  parameter int NUM_BANK = NUM_VERTEX_UNIT,
  parameter int BW       = FV_BANDWIDTH,
  parameter int NODE_W   = $clog2(MAX_NODE_ID),
  parameter int BEATS    = FV_SIZE / FV_BANDWIDTH,
  parameter int ADDR_W   = NODE_W + $clog2(BEATS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BANK-1:0]        bank_req,
  input  logic [NUM_BANK-1:0]        bank_grant_valid,
  input  logic [NUM_BANK-1:0]        bank_sos,
  input  logic [NUM_BANK-1:0]        bank_eos,
  input  logic [NUM_BANK*BW-1:0]     bank_data,
  input  logic [NUM_BANK*NODE_W-1:0] bank_node_id,
  input  logic                       buf_empty,
  output logic [NUM_BANK-1:0]        req_grant,
  output logic                       sram_wen,
  output logic [ADDR_W-1:0]          sram_addr,
  output logic [BW-1:0]              sram_wdata,
  output logic [NODE_W:0]            nodes_written,
  output logic                       drain_done,
  output logic                       protocol_err
);
  localparam int IDX_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int LB    = $clog2(BEATS);
  localparam int CNT_W = LB + 1;

  arb_state_e              state, state_nxt;
  logic [NUM_BANK-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NODE_W-1:0]       node_q, node_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NODE_W:0]         nw_q, nw_d;
  logic                    err_q, err_d;
  logic                    drain_q;
  logic                    done, release_g;
  logic [IDX_W-1:0]        next_ptr;
  Out_SRAM_Wr              wr_q, wr_d;
  Bank_Req2Req_Output_SRAM bank [NUM_BANK];
  Bank_Req2Req_Output_SRAM sel;
  logic [NUM_BANK-1:0]     pick_grant;
  logic [IDX_W-1:0]        pick_idx;

  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      bank[b].req         = bank_req[b];
      bank[b].grant_valid = bank_grant_valid[b];
      bank[b].sos         = bank_sos[b];
      bank[b].eos         = bank_eos[b];
      bank[b].data        = bank_data[b*BW +: BW];
      bank[b].node_id     = bank_node_id[b*NODE_W +: NODE_W];
    end
  end

  // Only the granted bank is ever looked at; everything else is ignored.
  assign sel      = bank[gidx_q];
  assign next_ptr = (gidx_q == IDX_W'(NUM_BANK - 1)) ? '0 : gidx_q + 1'b1;

  output_sram_req_arbiter_rr_pick #(
    .N     (NUM_BANK),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (bank_req),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    node_d    = node_q;
    cnt_d     = cnt_q;
    nw_d      = nw_q;
    err_d     = err_q;
    wr_d      = wr_q;
    wr_d.wen  = 1'b0;
    done      = 1'b0;
    release_g = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (|bank_req) begin
          grant_d   = pick_grant;
          gidx_d    = pick_idx;
          state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (sel.grant_valid && sel.sos) begin
          node_d     = sel.node_id;
          cnt_d      = CNT_W'(1);
          wr_d.wen   = 1'b1;
          wr_d.addr  = {sel.node_id, LB'(0)};
          wr_d.wdata = sel.data;
          state_nxt  = ARB_STREAM;
          done       = sel.eos;
        end else if (!sel.req) begin
          release_g = 1'b1;
        end
      end
      ARB_STREAM: begin
        if (sel.grant_valid) begin
          if (sel.sos) begin
            err_d = 1'b1;
          end else begin
            // Overlong vectors keep draining until eos but never write past the last beat slot.
            if (cnt_q == CNT_W'(BEATS)) begin
              err_d = 1'b1;
            end else begin
              wr_d.wen   = 1'b1;
              wr_d.addr  = {node_q, cnt_q[LB-1:0]};
              wr_d.wdata = sel.data;
              cnt_d      = cnt_q + 1'b1;
            end
            done = sel.eos;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (done && (nw_q != '1)) nw_d = nw_q + 1'b1;
    if (done || release_g) begin
      rr_ptr_d  = next_ptr;
      grant_d   = '0;
      state_nxt = ARB_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ARB_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      node_q   <= '0;
      cnt_q    <= '0;
      nw_q     <= '0;
      err_q    <= 1'b0;
      wr_q     <= '0;
      drain_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      node_q   <= node_d;
      cnt_q    <= cnt_d;
      nw_q     <= nw_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      drain_q  <= (state == ARB_IDLE) && !(|bank_req) && buf_empty;
    end
  end

  assign req_grant     = grant_q;
  assign sram_wen      = wr_q.wen;
  assign sram_addr     = wr_q.addr;
  assign sram_wdata    = wr_q.wdata;
  assign nodes_written = nw_q;
  assign drain_done    = drain_q;
  assign protocol_err  = err_q;
endmodule

// File: tb/tb_output_sram_req_arbiter.sv
// Directed vector bench for output_sram_req_arbiter: 4 banks, 16-bit beats, 6-bit node id, 4 beats per vector.
module tb_output_sram_req_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  bank_req, bank_grant_valid, bank_sos, bank_eos;
  logic [63:0] bank_data;
  logic [23:0] bank_node_id;
  logic        buf_empty;
  logic [3:0]  req_grant;
  logic        sram_wen;
  logic [7:0]  sram_addr;
  logic [15:0] sram_wdata;
  logic [6:0]  nodes_written;
  logic        drain_done;
  logic        protocol_err;

  int tests = 0;
  int fails = 0;

  output_sram_req_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .bank_req         (bank_req),
    .bank_grant_valid (bank_grant_valid),
    .bank_sos         (bank_sos),
    .bank_eos         (bank_eos),
    .bank_data        (bank_data),
    .bank_node_id     (bank_node_id),
    .buf_empty        (buf_empty),
    .req_grant        (req_grant),
    .sram_wen         (sram_wen),
    .sram_addr        (sram_addr),
    .sram_wdata       (sram_wdata),
    .nodes_written    (nodes_written),
    .drain_done       (drain_done),
    .protocol_err     (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req, gv, sos, eos;
    logic [5:0]  nid;
    logic [11:0] dat;
    logic        be;
    logic [3:0]  e_grant;
    logic        e_wen;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;
    logic [6:0]  e_nw;
    logic        e_drain, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] gv,
                              input logic [3:0] sos, input logic [3:0] eos, input logic [5:0] nid,
                              input logic [11:0] dat, input logic be, input logic [3:0] eg,
                              input logic ew, input logic [7:0] ea, input logic [15:0] ed,
                              input logic [6:0] enw, input logic edr, input logic eer);
    vec_t v;
    v.rst = rst; v.req = req; v.gv = gv; v.sos = sos; v.eos = eos; v.nid = nid; v.dat = dat; v.be = be;
    v.e_grant = eg; v.e_wen = ew; v.e_addr = ea; v.e_wdata = ed; v.e_nw = enw; v.e_drain = edr; v.e_err = eer;
    return v;
  endfunction

  // Bank b drives data {b, dat} so a write from the wrong bank is visible in wdata.
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] gv, input logic [3:0] so,
                       input logic [3:0] eo, input logic [5:0] nid, input logic [11:0] dat, input logic be);
    reset = r; bank_req = rq; bank_grant_valid = gv; bank_sos = so; bank_eos = eo; buf_empty = be;
    for (int b = 0; b < 4; b++) begin
      bank_data[b*16 +: 16]  = {4'(b), dat};
      bank_node_id[b*6 +: 6] = nid;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] gv, input logic [3:0] so,
                      input logic [3:0] eo, input logic [5:0] nid, input logic [11:0] dat, input logic be);
    drive(r, rq, gv, so, eo, nid, dat, be);
    @(negedge clk);
  endtask

  initial begin
    // reset and drain
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 6'd0, 12'h000, 1, 4'b0000, 0, 8'd0, 16'h0000, 7'd0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 6'd0, 12'h000, 1, 4'b0000, 0, 8'd0, 16'h0000, 7'd0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 6'd0, 12'h000, 1, 4'b0000, 0, 8'd0, 16'h0000, 7'd0, 1, 0));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 6'd0, 12'h000, 0, 4'b0000, 0, 8'd0, 16'h0000, 7'd0, 0, 0));
    // single bank 2, node 5, 4 beats; bank 0 sos on beat 0 must be ignored
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 6'd5, 12'h000, 0, 4'b0100, 0, 8'd0, 16'h0000, 7'd0, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0101, 4'b0101, 4'b0000, 6'd5, 12'h100, 0, 4'b0100, 1, 8'd20, 16'h2100, 7'd0, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 6'd5, 12'h101, 0, 4'b0100, 1, 8'd21, 16'h2101, 7'd0, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 6'd5, 12'h102, 0, 4'b0100, 1, 8'd22, 16'h2102, 7'd0, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 6'd5, 12'h103, 0, 4'b0000, 1, 8'd23, 16'h2103, 7'd1, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 6'd0, 12'h000, 1, 4'b0000, 0, 8'd0, 16'h0000, 7'd1, 1, 0));
    // all banks requesting with 1-beat packets; pointer sits at 3 after bank 2 finished
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b1000, 0, 8'd0, 16'h0000, 7'd1, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b0000, 1, 8'd36, 16'h30C5, 7'd2, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b0001, 0, 8'd0, 16'h0000, 7'd2, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b0000, 1, 8'd36, 16'h00C5, 7'd3, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b0010, 0, 8'd0, 16'h0000, 7'd3, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b0000, 1, 8'd36, 16'h10C5, 7'd4, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b0100, 0, 8'd0, 16'h0000, 7'd4, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b0000, 1, 8'd36, 16'h20C5, 7'd5, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b1000, 0, 8'd0, 16'h0000, 7'd5, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 6'd9, 12'h0C5, 0, 4'b0000, 1, 8'd36, 16'h30C5, 7'd6, 0, 0));
    // bank 1 granted then drops req before sos: release, pointer moves to 2
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 6'd0, 12'h000, 0, 4'b0010, 0, 8'd0, 16'h0000, 7'd6, 0, 0));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 6'd0, 12'h000, 0, 4'b0010, 0, 8'd0, 16'h0000, 7'd6, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 6'd0, 12'h000, 1, 4'b0000, 0, 8'd0, 16'h0000, 7'd6, 0, 0));
    // bank 2 with a 3-cycle stall mid-stream, node 7
    vecs.push_back(mk(1, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 6'd7, 12'h000, 0, 4'b0100, 0, 8'd0, 16'h0000, 7'd6, 0, 0));
    vecs.push_back(mk(1, 4'b0110, 4'b0100, 4'b0100, 4'b0000, 6'd7, 12'h010, 0, 4'b0100, 1, 8'd28, 16'h2010, 7'd6, 0, 0));
    vecs.push_back(mk(1, 4'b0110, 4'b0010, 4'b0010, 4'b0000, 6'd7, 12'h3FF, 0, 4'b0100, 0, 8'd0, 16'h0000, 7'd6, 0, 0));
    vecs.push_back(mk(1, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 6'd7, 12'h3FF, 0, 4'b0100, 0, 8'd0, 16'h0000, 7'd6, 0, 0));
    vecs.push_back(mk(1, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 6'd7, 12'h3FF, 0, 4'b0100, 0, 8'd0, 16'h0000, 7'd6, 0, 0));
    vecs.push_back(mk(1, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 6'd7, 12'h011, 0, 4'b0100, 1, 8'd29, 16'h2011, 7'd6, 0, 0));
    vecs.push_back(mk(1, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 6'd7, 12'h012, 0, 4'b0100, 1, 8'd30, 16'h2012, 7'd6, 0, 0));
    vecs.push_back(mk(1, 4'b0110, 4'b0100, 4'b0000, 4'b0100, 6'd7, 12'h013, 0, 4'b0000, 1, 8'd31, 16'h2013, 7'd7, 0, 0));
    // single-beat packet from bank 1, node 3
    vecs.push_back(mk(1, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 6'd3, 12'h000, 0, 4'b0010, 0, 8'd0, 16'h0000, 7'd7, 0, 0));
    vecs.push_back(mk(1, 4'b0110, 4'b0010, 4'b0010, 4'b0010, 6'd3, 12'h055, 0, 4'b0000, 1, 8'd12, 16'h1055, 7'd8, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 6'd3, 12'h000, 1, 4'b0000, 0, 8'd0, 16'h0000, 7'd8, 1, 0));
    // overlong vector from bank 2, node 1: 6 beats, only 4 written, still counted
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 6'd1, 12'h000, 0, 4'b0100, 0, 8'd0, 16'h0000, 7'd8, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 6'd1, 12'h0E0, 0, 4'b0100, 1, 8'd4, 16'h20E0, 7'd8, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 6'd1, 12'h0E1, 0, 4'b0100, 1, 8'd5, 16'h20E1, 7'd8, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 6'd1, 12'h0E2, 0, 4'b0100, 1, 8'd6, 16'h20E2, 7'd8, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 6'd1, 12'h0E3, 0, 4'b0100, 1, 8'd7, 16'h20E3, 7'd8, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 6'd1, 12'h0E4, 0, 4'b0100, 0, 8'd0, 16'h0000, 7'd8, 0, 1));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 6'd1, 12'h0E5, 0, 4'b0000, 0, 8'd0, 16'h0000, 7'd9, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].gv, vecs[i].sos, vecs[i].eos, vecs[i].nid, vecs[i].dat, vecs[i].be);
      @(negedge clk);
      chk($sformatf("v%0d grant", i), 32'(req_grant), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d wen", i), 32'(sram_wen), 32'(vecs[i].e_wen));
      chk($sformatf("v%0d nodes_written", i), 32'(nodes_written), 32'(vecs[i].e_nw));
      chk($sformatf("v%0d drain_done", i), 32'(drain_done), 32'(vecs[i].e_drain));
      chk($sformatf("v%0d protocol_err", i), 32'(protocol_err), 32'(vecs[i].e_err));
      if (vecs[i].e_wen) begin
        chk($sformatf("v%0d addr", i), 32'(sram_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d wdata", i), 32'(sram_wdata), 32'(vecs[i].e_wdata));
      end
    end

    // Reset after beat 1 of a bank-3 vector: everything clears, nothing more is written.
    step(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 6'd2, 12'h000, 0);
    chk("rst grant", 32'(req_grant), 32'h8);
    step(1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 6'd2, 12'h0A0, 0);
    chk("rst beat0 addr", 32'(sram_addr), 32'd8);
    chk("rst beat0 wdata", 32'(sram_wdata), 32'h30A0);
    step(1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 6'd2, 12'h0A1, 0);
    chk("rst beat1 wen", 32'(sram_wen), 32'd1);
    chk("rst beat1 addr", 32'(sram_addr), 32'd9);
    step(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 6'd2, 12'h0A2, 0);
    chk("in-reset grant", 32'(req_grant), 32'd0);
    chk("in-reset wen", 32'(sram_wen), 32'd0);
    chk("in-reset addr", 32'(sram_addr), 32'd0);
    chk("in-reset wdata", 32'(sram_wdata), 32'd0);
    chk("in-reset nodes_written", 32'(nodes_written), 32'd0);
    chk("in-reset drain", 32'(drain_done), 32'd0);
    chk("in-reset err", 32'(protocol_err), 32'd0);
    step(1, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 6'd2, 12'h0A3, 1);
    chk("post-reset wen", 32'(sram_wen), 32'd0);
    chk("post-reset drain", 32'(drain_done), 32'd1);
    chk("post-reset nodes_written", 32'(nodes_written), 32'd0);
    step(1, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 6'd2, 12'h0A3, 1);
    chk("post-reset wen2", 32'(sram_wen), 32'd0);

    // Second sos while streaming is dropped and flagged; eos still completes.
    step(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 6'd4, 12'h000, 0);
    chk("sos2 grant", 32'(req_grant), 32'h1);
    step(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 6'd4, 12'h0B0, 0);
    chk("sos2 beat0 addr", 32'(sram_addr), 32'd16);
    chk("sos2 beat0 wdata", 32'(sram_wdata), 32'h00B0);
    step(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 6'd4, 12'h0B1, 0);
    chk("sos2 dup wen", 32'(sram_wen), 32'd0);
    chk("sos2 dup err", 32'(protocol_err), 32'd1);
    step(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 6'd4, 12'h0B2, 0);
    chk("sos2 eos wen", 32'(sram_wen), 32'd1);
    chk("sos2 eos addr", 32'(sram_addr), 32'd17);
    chk("sos2 eos wdata", 32'(sram_wdata), 32'h00B2);
    chk("sos2 nodes_written", 32'(nodes_written), 32'd1);
    chk("sos2 grant released", 32'(req_grant), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
